// File: rtl/update_pkg.sv
// Shared sizing, types and FSM encoding for the J-row / sigma beat interface.
package update_pkg;

  localparam int NUM_ROWS_PER_CLK = 4;
  localparam int VECTOR_SIZE      = 8;
  localparam int DATA_WIDTH       = 4;
  localparam int ADDR_WIDTH       = $clog2(VECTOR_SIZE);

  typedef logic signed [DATA_WIDTH-1:0] j_elem_t;
  typedef j_elem_t [VECTOR_SIZE-1:0]    j_row_t;
  typedef logic [ADDR_WIDTH-1:0]        row_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } streamer_state_e;

endpackage

// File: rtl/lowest_k_picker.sv
// Picks the K lowest set bits of a mask, ascending, one per lane.
// Also returns the mask with those bits cleared so a scanner can iterate.
module lowest_k_picker #(
  parameter int WIDTH = 8,
  parameter int K     = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0]        mask,
  output logic [K-1:0][IDX_W-1:0] idx,
  output logic [K-1:0]            valid,
  output logic [WIDTH-1:0]        rem
);

  logic [WIDTH-1:0] scan;

  // Peel off the lowest remaining set bit once per lane.
  always_comb begin
    scan  = mask;
    idx   = '0;
    valid = '0;
    for (int l = 0; l < K; l++) begin
      valid[l] = |scan;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (scan[i]) idx[l] = IDX_W'(i);
      end
      if (valid[l]) scan[idx[l]] = 1'b0;
    end
    rem = scan;
  end

endmodule

// File: rtl/j_row_streamer.sv
// Streams J rows of flipped spins to the dot-product updater, a beat of up to
// NUM_ROWS_PER_CLK rows at a time, with credit-limited outstanding beats.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_ISSUE  | reading the next group of rows whenever credit is available
// ST_DRAIN  | all rows read; waiting for the last beats to be acknowledged
// ST_FINISH | batch complete; batch_done pulses on the way back to idle
module j_row_streamer
  import update_pkg::*;
#(
  parameter int NUM_ROWS_PER_CLK = update_pkg::NUM_ROWS_PER_CLK,
  parameter int VECTOR_SIZE      = update_pkg::VECTOR_SIZE,
  parameter int DATA_WIDTH       = update_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int ADDR_WIDTH       = $clog2(VECTOR_SIZE)
) (
  input  logic                                                            clk,
  input  logic                                                            rst_n,
  input  logic                                                            start,
  input  logic [VECTOR_SIZE-1:0]                                          flip_mask,
  input  logic [VECTOR_SIZE-1:0]                                          sigma_new,
  output logic                                                            busy,
  output logic                                                            batch_done,
  output logic [NUM_ROWS_PER_CLK-1:0]                                     mem_rd_en,
  output logic [NUM_ROWS_PER_CLK-1:0][ADDR_WIDTH-1:0]                     mem_rd_addr,
  input  logic [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0]    mem_rd_data,
  output logic signed [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_rows,
  output logic [NUM_ROWS_PER_CLK-1:0]                                     j_rows_valid,
  output logic [NUM_ROWS_PER_CLK-1:0]                                     sigma_bits,
  input  logic                                                            dp_done,
  output logic                                                            err_unexpected_done
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  streamer_state_e state;
  logic [VECTOR_SIZE-1:0]      rem_mask;
  logic [VECTOR_SIZE-1:0]      sig_reg;
  logic [CNT_W-1:0]            outs_cnt;
  logic [NUM_ROWS_PER_CLK-1:0] pipe_valid;
  logic [NUM_ROWS_PER_CLK-1:0] pipe_sig;

  logic [NUM_ROWS_PER_CLK-1:0][ADDR_WIDTH-1:0] pick_idx;
  logic [NUM_ROWS_PER_CLK-1:0]                 pick_valid;
  logic [NUM_ROWS_PER_CLK-1:0]                 pick_sig;
  logic [VECTOR_SIZE-1:0]                      pick_rem;
  logic                                        issue;
  logic                                        ack;

  lowest_k_picker #(
    .WIDTH (VECTOR_SIZE),
    .K     (NUM_ROWS_PER_CLK),
    .IDX_W (ADDR_WIDTH)
  ) u_picker (
    .mask  (rem_mask),
    .idx   (pick_idx),
    .valid (pick_valid),
    .rem   (pick_rem)
  );

  // outs_cnt counts from the read, so it already covers the beat in flight.
  assign issue = (state == ST_ISSUE) && (outs_cnt < CNT_W'(MAX_OUTSTANDING));
  assign ack   = dp_done && (outs_cnt != '0);
  assign busy  = (state != ST_IDLE);

  // Read requests and the sigma bit of each picked spin.
  always_comb begin
    mem_rd_en   = issue ? pick_valid : '0;
    mem_rd_addr = '0;
    pick_sig    = '0;
    for (int l = 0; l < NUM_ROWS_PER_CLK; l++) begin
      if (issue && pick_valid[l]) mem_rd_addr[l] = pick_idx[l];
      pick_sig[l] = pick_valid[l] & sig_reg[pick_idx[l]];
    end
  end

  // Batch sequencing: latch the batch, walk the mask, wait for acks, report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rem_mask   <= '0;
      sig_reg    <= '0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_mask <= flip_mask;
            sig_reg  <= sigma_new;
            state    <= (flip_mask != '0) ? ST_ISSUE : ST_FINISH;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            rem_mask <= pick_rem;
            if (pick_rem == '0) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outs_cnt == '0 && pipe_valid == '0) state <= ST_FINISH;
        end
        ST_FINISH: begin
          batch_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-beat credit and the sticky unexpected-ack flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outs_cnt            <= '0;
      err_unexpected_done <= 1'b0;
    end else begin
      if (dp_done && outs_cnt == '0) err_unexpected_done <= 1'b1;
      case ({issue, ack})
        2'b10:   outs_cnt <= outs_cnt + 1'b1;
        2'b01:   outs_cnt <= outs_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Lane valid and sigma travel alongside the one-cycle memory read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_sig   <= '0;
    end else begin
      pipe_valid <= mem_rd_en;
      pipe_sig   <= issue ? pick_sig : '0;
    end
  end

  // Invalid lanes are forced to zero so stale memory data never leaks out.
  always_comb begin
    j_rows = '0;
    for (int l = 0; l < NUM_ROWS_PER_CLK; l++) begin
      if (pipe_valid[l]) j_rows[l] = mem_rd_data[l];
    end
  end

  assign j_rows_valid = pipe_valid;
  assign sigma_bits   = pipe_sig;

endmodule

// File: tb/tb_j_row_streamer.sv
// Bench for j_row_streamer: two instances (credit 4 and credit 1), a J memory
// model, a dp_done responder and a set-bit/chunk reference model.
module tb_j_row_streamer;
  import update_pkg::*;

  localparam int N  = NUM_ROWS_PER_CLK;
  localparam int VS = VECTOR_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef struct {
    int             ed;
    logic [N-1:0]   v;
    logic [N-1:0]   s;
    logic [127:0]   r;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [VS-1:0] flip_mask = '0;
  logic [VS-1:0] sigma_new = '0;
  logic st [2];
  logic dpd [2];
  logic busy [2];
  logic bdn [2];
  logic err [2];
  logic [N-1:0] rdv [2];
  logic [N-1:0][AW-1:0] rda [2];
  logic [N-1:0][VS-1:0][DW-1:0] rdd [2];
  logic signed [N-1:0][VS-1:0][DW-1:0] jr [2];
  logic [N-1:0] jv [2];
  logic [N-1:0] sb [2];

  j_row_t jmem [VS];
  int maxo [2] = '{4, 1};
  int cyc = 0;
  int nchk = 0, nerr = 0;
  int rd_cnt [2] = '{0, 0};
  int bd_count [2] = '{0, 0};
  int bd_edge [2] = '{0, 0};
  int dlo [2] = '{1, 1};
  int dhi [2] = '{1, 1};
  logic spur [2] = '{1'b0, 1'b0};
  beat_t bq [2][$];
  int dq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  j_row_streamer #(.MAX_OUTSTANDING(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .flip_mask(flip_mask), .sigma_new(sigma_new),
    .busy(busy[0]), .batch_done(bdn[0]), .mem_rd_en(rdv[0]), .mem_rd_addr(rda[0]),
    .mem_rd_data(rdd[0]), .j_rows(jr[0]), .j_rows_valid(jv[0]), .sigma_bits(sb[0]),
    .dp_done(dpd[0]), .err_unexpected_done(err[0]));

  j_row_streamer #(.MAX_OUTSTANDING(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .flip_mask(flip_mask), .sigma_new(sigma_new),
    .busy(busy[1]), .batch_done(bdn[1]), .mem_rd_en(rdv[1]), .mem_rd_addr(rda[1]),
    .mem_rd_data(rdd[1]), .j_rows(jr[1]), .j_rows_valid(jv[1]), .sigma_bits(sb[1]),
    .dp_done(dpd[1]), .err_unexpected_done(err[1]));

  // J memory: one-cycle read latency; non-enabled lanes return all-ones junk.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    always @(posedge clk)
      for (int l = 0; l < N; l++)
        rdd[g][l] <= rdv[g][l] ? jmem[rda[g][l]] : {(VS*DW){1'b1}};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observes beats/batch_done at negedge and plays the consumer's dp_done.
  task automatic mon(input int i);
    int pend[$];
    int b = 0, d = 0, d_last = 0, d_prev = 0, due = 0, last_due = 0;
    beat_t bt;
    forever begin
      @(negedge clk);
      d_prev = d_last;
      d_last = d;
      if (!rst_n) begin
        pend.delete();
        b = 0; d = 0; d_last = 0; last_due = 0;
        dpd[i] = 1'b0;
        spur[i] = 1'b0;
      end else begin
        if (rdv[i] != '0) rd_cnt[i]++;
        if (bdn[i]) begin bd_count[i]++; bd_edge[i] = cyc + 1; end
        if (jv[i] != '0) begin
          b++;
          chk($sformatf("credit%0d", i), 128'(b - d_prev <= maxo[i]), 128'(1));
          bt.ed = cyc + 1; bt.v = jv[i]; bt.s = sb[i]; bt.r = jr[i];
          bq[i].push_back(bt);
          due = cyc + int'($urandom_range(dhi[i], dlo[i]));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back(due);
        end
        dpd[i] = 1'b0;
        if (pend.size() > 0 && pend[0] <= cyc) begin
          void'(pend.pop_front());
          dpd[i] = 1'b1; d++;
          dq[i].push_back(cyc + 1);
        end else if (spur[i]) begin
          spur[i] = 1'b0;
          dpd[i] = 1'b1; d++;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic check_idle(input int i, input string tag);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_bd"}, bdn[i], 0);
    chk({tag, "_rden"}, rdv[i], 0);
    chk({tag, "_rdaddr"}, rda[i], 0);
    chk({tag, "_jv"}, jv[i], 0);
    chk({tag, "_sig"}, sb[i], 0);
    chk({tag, "_jrows"}, jr[i], 0);
    chk({tag, "_err"}, err[i], 0);
  endtask

  task automatic run_batch(input int i, input logic [VS-1:0] m, input logic [VS-1:0] s,
                           input int lo, input int hi, input bit overlap);
    int t0, bd0, rd0, exp_nb;
    int idx[$];
    logic [N-1:0] ev, es;
    logic [127:0] er;
    bq[i].delete(); dq[i].delete();
    dlo[i] = lo; dhi[i] = hi;
    bd0 = bd_count[i]; rd0 = rd_cnt[i];
    flip_mask = m; sigma_new = s; st[i] = 1'b1;
    t0 = cyc + 1;
    step();
    st[i] = 1'b0;
    chk($sformatf("busy%0d_%0h", i, m), busy[i], 1);
    if (overlap) begin
      step();
      flip_mask = 8'h0F; sigma_new = ~s; st[i] = 1'b1;
      step();
      st[i] = 1'b0;
    end
    for (int n = 0; n < 300 && bd_count[i] == bd0; n++) step();
    if (bd_count[i] == bd0) chk($sformatf("timeout%0d_%0h", i, m), 0, 1);
    repeat (4) step();
    chk($sformatf("bd_once%0d_%0h", i, m), bd_count[i] - bd0, 1);
    chk($sformatf("err%0d_%0h", i, m), err[i], 0);
    for (int b = 0; b < VS; b++) if (m[b]) idx.push_back(b);
    exp_nb = (idx.size() + N - 1) / N;
    chk($sformatf("nbeats%0d_%0h", i, m), bq[i].size(), exp_nb);
    chk($sformatf("rdcyc%0d_%0h", i, m), rd_cnt[i] - rd0, exp_nb);
    for (int b = 0; b < exp_nb && b < bq[i].size(); b++) begin
      ev = '0; es = '0; er = '0;
      for (int l = 0; l < N && b * N + l < idx.size(); l++) begin
        ev[l] = 1'b1;
        es[l] = s[idx[b*N+l]];
        er[l*VS*DW +: VS*DW] = jmem[idx[b*N+l]];
      end
      chk($sformatf("valid%0d_%0h_b%0d", i, m, b), bq[i][b].v, ev);
      chk($sformatf("sigma%0d_%0h_b%0d", i, m, b), bq[i][b].s, es);
      chk($sformatf("rows%0d_%0h_b%0d", i, m, b), bq[i][b].r, er);
    end
    if (exp_nb == 0) begin
      chk($sformatf("empty_bd_edge%0d", i), bd_edge[i], t0 + 2);
    end else begin
      if (bq[i].size() > 0) chk($sformatf("lat%0d_%0h", i, m), bq[i][0].ed, t0 + 2);
      if (dq[i].size() > 0)
        chk($sformatf("bd_after_ack%0d_%0h", i, m), 128'(bd_edge[i] > dq[i][dq[i].size()-1]), 1);
    end
  endtask

  initial begin
    int bd0;
    st[0] = 1'b0; st[1] = 1'b0; dpd[0] = 1'b0; dpd[1] = 1'b0;
    for (int r = 0; r < VS; r++)
      for (int c = 0; c < VS; c++) jmem[r][c] = j_elem_t'($urandom_range(15, 0));
    for (int c = 0; c < VS; c++) jmem[0][c] = 4'sd1;
    repeat (3) step();
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst_n = 1'b1;
    step();

    run_batch(0, 8'h01, 8'h01, 1, 3, 1'b0);
    chk("single_row0", bq[0].size() > 0 ? bq[0][0].r[31:0] : 32'h0, 32'h1111_1111);
    run_batch(0, 8'hFF, 8'hF0, 1, 4, 1'b0);
    if (bq[0].size() == 2) chk("b2b", bq[0][1].ed - bq[0][0].ed, 1);
    run_batch(0, 8'b1010_0110, 8'($urandom), 1, 4, 1'b0);
    run_batch(0, 8'b0001_0000, 8'($urandom), 1, 4, 1'b0);
    run_batch(0, 8'h00, 8'($urandom), 1, 4, 1'b0);
    run_batch(0, 8'hFF, 8'($urandom), 6, 8, 1'b1);
    for (int k = 0; k < 10; k++) run_batch(0, 8'($urandom), 8'($urandom), 1, 6, 1'b0);
    for (int k = 0; k < 6; k++) run_batch(1, 8'($urandom), 8'($urandom), 1, 6, 1'b0);

    run_batch(1, 8'hFF, 8'($urandom), 5, 5, 1'b0);
    if (bq[1].size() == 2 && dq[1].size() > 0)
      chk("stall_after_ack", 128'(bq[1][1].ed > dq[1][0]), 1);
    spur[1] = 1'b1;
    repeat (3) step();
    chk("spurious_err1", err[1], 1);
    chk("spurious_err0", err[0], 0);

    bq[0].delete(); dlo[0] = 10; dhi[0] = 10; bd0 = bd_count[0];
    flip_mask = 8'hFF; sigma_new = 8'($urandom); st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    for (int n = 0; n < 50 && bq[0].size() < 2; n++) step();
    chk("rst_beats", bq[0].size(), 2);
    step(); step();
    chk("rst_in_drain_busy", busy[0], 1);
    rst_n = 1'b0;
    step();
    check_idle(0, "midrst0");
    check_idle(1, "midrst1");
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("rst_no_bd", bd_count[0] - bd0, 0);
    run_batch(0, 8'($urandom), 8'($urandom), 1, 5, 1'b0);
    run_batch(1, 8'($urandom), 8'($urandom), 1, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
